// File: rtl/msg_buffer_pkg.sv
// Shared constants and state encodings for the editable message buffer and its echo path.
package msg_buffer_pkg;

   localparam logic [7:0] CHAR_CR  = 8'h0D;
   localparam logic [7:0] CHAR_ESC = 8'h1B;
   localparam logic [7:0] CHAR_BS  = 8'h08;
   localparam logic [7:0] CHAR_LO  = 8'h20;
   localparam logic [7:0] CHAR_HI  = 8'h7E;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } main_state_t;

   typedef enum logic [1:0] {
      E_IDLE  = 2'd0,
      E_PEND  = 2'd1,
      E_GUARD = 2'd2
   } echo_state_t;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= CHAR_LO) && (b <= CHAR_HI);
   endfunction

endpackage

// File: rtl/msg_buffer_echo.sv
// Echo path: one holding register that waits for the UART transmitter to go idle,
// then issues a single transmit pulse followed by a guard cycle.
module uart_echo_tx
   import msg_buffer_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst,
   input  logic       req_i,
   input  logic [7:0] byte_i,
   input  logic       tx_busy_i,
   output logic       tx_start_o,
   output logic [7:0] tx_byte_o,
   output logic       echo_drop_o
);

   echo_state_t state_q;
   logic [7:0]  held_q;
   logic [7:0]  tx_byte_q;
   logic        tx_start_q;
   logic        echo_drop_q;

   // Echo sequencing; the guard cycle gives the UART time to raise is_transmitting.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q     <= E_IDLE;
         held_q      <= 8'h00;
         tx_byte_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         echo_drop_q <= 1'b0;
      end else begin
         tx_start_q  <= 1'b0;
         echo_drop_q <= 1'b0;
         case (state_q)
            E_IDLE: begin
               if (req_i) begin
                  held_q  <= byte_i;
                  state_q <= E_PEND;
               end
            end
            E_PEND: begin
               echo_drop_q <= req_i;
               if (!tx_busy_i) begin
                  tx_byte_q  <= held_q;
                  tx_start_q <= 1'b1;
                  state_q    <= E_GUARD;
               end
            end
            E_GUARD: begin
               echo_drop_q <= req_i;
               state_q     <= E_IDLE;
            end
            default: state_q <= E_IDLE;
         endcase
      end
   end

   assign tx_start_o  = tx_start_q;
   assign tx_byte_o   = tx_byte_q;
   assign echo_drop_o = echo_drop_q;

endmodule

// File: rtl/msg_buffer.sv
// Editable message store between the UART receiver and the LED scanner: line-edit
// decoding, a flop-array character memory with a registered read port, and echo.
module msg_buffer
   import msg_buffer_pkg::*;
#(
   parameter int         DEPTH     = 16,
   parameter int         AW        = 4,
   parameter logic [7:0] FILL_CHAR = 8'h20
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic          rx_valid,
   input  logic [7:0]    rx_byte,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic [AW:0]   length,
   output logic          busy,
   output logic          rx_drop,
   output logic          tx_start,
   output logic [7:0]    tx_byte,
   input  logic          tx_busy,
   output logic          echo_drop
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   main_state_t   state_q;
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] cnt_q;
   logic [AW:0]   length_q;
   logic          busy_q;
   logic          rx_drop_q;
   logic [7:0]    rd_data_q;
   logic [7:0]    mem_q [DEPTH];

   logic          is_print_s;
   logic [AW:0]   wptr_inc_s;
   logic          mem_we_d;
   logic [AW-1:0] mem_waddr_d;
   logic [7:0]    mem_wdata_d;
   logic          echo_req_d;

   assign is_print_s = is_printable(rx_byte);
   assign wptr_inc_s = {1'b0, wptr_q} + (AW + 1)'(1);

   // Write-port and echo-request decode for the current cycle.
   always_comb begin
      mem_we_d    = 1'b0;
      mem_waddr_d = '0;
      mem_wdata_d = FILL_CHAR;
      echo_req_d  = 1'b0;
      if (state_q == CLEAR) begin
         mem_we_d    = 1'b1;
         mem_waddr_d = cnt_q;
      end else if (rx_valid) begin
         if (is_print_s) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = wptr_q;
            mem_wdata_d = rx_byte;
            echo_req_d  = 1'b1;
         end else if (rx_byte == CHAR_CR) begin
            echo_req_d = 1'b1;
         end else if ((rx_byte == CHAR_BS) && (wptr_q != '0)) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = wptr_q - AW'(1);
            echo_req_d  = 1'b1;
         end else begin
            echo_req_d = 1'b0;
         end
      end else begin
         mem_we_d = 1'b0;
      end
   end

   // Main edit FSM: cursor, length and the CLEAR sweep counter.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         wptr_q    <= '0;
         cnt_q     <= '0;
         length_q  <= '0;
         busy_q    <= 1'b0;
         rx_drop_q <= 1'b0;
      end else begin
         rx_drop_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rx_valid) begin
                  if (is_print_s) begin
                     wptr_q <= wptr_q + AW'(1);
                     if (wptr_inc_s > length_q) length_q <= wptr_inc_s;
                  end else if (rx_byte == CHAR_CR) begin
                     wptr_q <= '0;
                  end else if ((rx_byte == CHAR_BS) && (wptr_q != '0)) begin
                     wptr_q <= wptr_q - AW'(1);
                     if (length_q == {1'b0, wptr_q}) length_q <= length_q - (AW + 1)'(1);
                  end else if (rx_byte == CHAR_ESC) begin
                     state_q <= CLEAR;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               rx_drop_q <= rx_valid;
               if (cnt_q == LAST_IDX) begin
                  state_q  <= IDLE;
                  wptr_q   <= '0;
                  length_q <= '0;
                  busy_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + AW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Character array and registered read; the read samples the pre-write contents.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= FILL_CHAR;
         rd_data_q <= FILL_CHAR;
      end else begin
         if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
         rd_data_q <= mem_q[rd_addr];
      end
   end

   uart_echo_tx u_echo (
      .clk_in      (clk_in),
      .rst         (rst),
      .req_i       (echo_req_d),
      .byte_i      (rx_byte),
      .tx_busy_i   (tx_busy),
      .tx_start_o  (tx_start),
      .tx_byte_o   (tx_byte),
      .echo_drop_o (echo_drop)
   );

   assign rd_data = rd_data_q;
   assign length  = length_q;
   assign busy    = busy_q;
   assign rx_drop = rx_drop_q;

endmodule

// File: tb/tb_msg_buffer.sv
// Directed bench for msg_buffer: line editing, clear sweep, read port timing and echo
// handshake against a simple UART transmitter model.
module tb_msg_buffer;

   logic       clk_in   = 1'b0;
   logic       rst      = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_byte  = 8'h00;
   logic [3:0] rd_addr  = 4'd0;
   logic       tx_busy  = 1'b0;
   logic [7:0] rd_data;
   logic [4:0] length;
   logic       busy;
   logic       rx_drop;
   logic       tx_start;
   logic [7:0] tx_byte;
   logic       echo_drop;

   int         n_checks = 0;
   int         n_err    = 0;
   int         busy_cnt = 0;
   int         viol     = 0;
   int         bcnt     = 0;
   logic [7:0] echo_q[$];

   msg_buffer dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .length    (length),
      .busy      (busy),
      .rx_drop   (rx_drop),
      .tx_start  (tx_start),
      .tx_byte   (tx_byte),
      .tx_busy   (tx_busy),
      .echo_drop (echo_drop)
   );

   always #5 clk_in = ~clk_in;

   // UART transmitter model: busy for six cycles after each transmit pulse.
   initial forever begin
      @(posedge clk_in);
      #2;
      if (rst) begin
         bcnt = 0;
      end else begin
         if (tx_start && tx_busy) viol++;
         if (tx_start) begin
            echo_q.push_back(tx_byte);
            bcnt = 6;
         end else if (bcnt > 0) begin
            bcnt--;
         end
      end
      tx_busy = (bcnt != 0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_in);
      #1;
      if (busy) busy_cnt++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      tick;
      rx_valid = 1'b0;
   endtask

   task automatic send_gap(input logic [7:0] b);
      send(b);
      idle(10);
   endtask

   task automatic chk_mem(input int addr, input logic [7:0] exp);
      rd_addr = 4'(addr);
      tick;
      check($sformatf("mem[%0d]", addr), 16'(rd_data), 16'(exp));
   endtask

   task automatic do_reset;
      rx_valid = 1'b0;
      rd_addr  = 4'd0;
      rst      = 1'b1;
      idle(2);
      rst = 1'b0;
      echo_q.delete();
      tick;
   endtask

   initial begin
      // 1: reset state and full read sweep
      do_reset;
      check("rst_rd_data", 16'(rd_data), 16'h0020);
      check("rst_length", 16'(length), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_tx_byte", 16'(tx_byte), 16'h0000);
      check("rst_tx_start", 16'(tx_start), 16'd0);
      for (int i = 0; i < 16; i++) chk_mem(i, 8'h20);

      // 2: "HI" with the second byte waiting out tx_busy
      do_reset;
      viol = 0;
      send(8'h48);
      idle(2);
      send(8'h49);
      idle(12);
      chk_mem(0, 8'h48);
      chk_mem(1, 8'h49);
      check("hi_length", 16'(length), 16'd2);
      check("hi_echo_cnt", 16'(echo_q.size()), 16'd2);
      if (echo_q.size() == 2) begin
         check("hi_echo0", 16'(echo_q[0]), 16'h0048);
         check("hi_echo1", 16'(echo_q[1]), 16'h0049);
      end
      check("hi_no_start_while_busy", 16'(viol), 16'd0);

      // 3: sixteen 'A's fill the buffer, 'B' wraps to position 0
      do_reset;
      for (int i = 0; i < 16; i++) send_gap(8'h41);
      check("full_length", 16'(length), 16'd16);
      send_gap(8'h42);
      chk_mem(0, 8'h42);
      chk_mem(1, 8'h41);
      chk_mem(15, 8'h41);
      check("wrap_length", 16'(length), 16'd16);
      send_gap(8'h43);
      chk_mem(1, 8'h43);
      check("wrap_length2", 16'(length), 16'd16);

      // 4: backspace erase and the wptr==0 no-op
      do_reset;
      send_gap(8'h41);
      send_gap(8'h42);
      send_gap(8'h43);
      send_gap(8'h08);
      send_gap(8'h08);
      chk_mem(0, 8'h41);
      chk_mem(1, 8'h20);
      chk_mem(2, 8'h20);
      check("bs_length1", 16'(length), 16'd1);
      send_gap(8'h08);
      check("bs_length0", 16'(length), 16'd0);
      check("bs_echo_cnt", 16'(echo_q.size()), 16'd6);
      send_gap(8'h08);
      check("bs_at0_echo_cnt", 16'(echo_q.size()), 16'd6);
      check("bs_at0_length", 16'(length), 16'd0);
      chk_mem(0, 8'h20);
      // backspace behind the end keeps length
      send_gap(8'h41);
      send_gap(8'h42);
      send_gap(8'h43);
      send_gap(8'h0D);
      send_gap(8'h58);
      send_gap(8'h08);
      chk_mem(0, 8'h20);
      check("bs_mid_length", 16'(length), 16'd3);

      // 5: ESC clear sweep with a dropped byte
      do_reset;
      send_gap(8'h58);
      send_gap(8'h59);
      send_gap(8'h5A);
      busy_cnt = 0;
      send(8'h1B);
      check("clr_busy_rise", 16'(busy), 16'd1);
      idle(2);
      send(8'h51);
      check("clr_rx_drop", 16'(rx_drop), 16'd1);
      tick;
      check("clr_rx_drop_pulse", 16'(rx_drop), 16'd0);
      for (int i = 0; i < 40 && busy; i++) tick;
      check("clr_busy_fall", 16'(busy), 16'd0);
      check("clr_busy_cycles", 16'(busy_cnt), 16'd16);
      check("clr_length", 16'(length), 16'd0);
      for (int i = 0; i < 16; i++) chk_mem(i, 8'h20);
      check("clr_echo_cnt", 16'(echo_q.size()), 16'd3);
      send_gap(8'h51);
      chk_mem(0, 8'h51);
      check("clr_q_length", 16'(length), 16'd1);

      // 6: CR home, read-before-write, echo drop
      do_reset;
      send_gap(8'h48);
      send_gap(8'h45);
      send_gap(8'h4C);
      send_gap(8'h4C);
      send_gap(8'h4F);
      send_gap(8'h0D);
      rd_addr = 4'd0;
      send(8'h4A);
      check("rbw_old", 16'(rd_data), 16'h0048);
      tick;
      check("rbw_new", 16'(rd_data), 16'h004A);
      check("cr_length", 16'(length), 16'd5);
      idle(10);
      send(8'h4B);
      send(8'h4C);
      check("echo_drop", 16'(echo_drop), 16'd1);
      tick;
      check("echo_drop_pulse", 16'(echo_drop), 16'd0);
      idle(12);
      check("drop_echo_cnt", 16'(echo_q.size()), 16'd8);
      if (echo_q.size() == 8) check("drop_last_echo", 16'(echo_q[7]), 16'h004B);
      chk_mem(1, 8'h4B);
      chk_mem(2, 8'h4C);
      check("drop_length", 16'(length), 16'd5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
